// File: rtl/gal_fuse_loader.sv
// Streams a GAL16V8 JEDEC binary image (4-byte header + 275 data bytes) into
// the fuse register, verifying magic, device id and a 16-bit byte-sum checksum.
module gal_fuse_loader #(
    parameter int          NUM_FUSES = 2194,
    parameter logic [7:0]  MAGIC     = 8'h6A,
    parameter logic [7:0]  DEVICE_ID = 8'h16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NUM_FUSES-1:0] fuses,
    output logic                 cfg_valid,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int NUM_BYTES = (NUM_FUSES + 7) / 8;
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);
    localparam int FI_W      = $clog2(NUM_FUSES);
    localparam int LAST_BITS = NUM_FUSES - 8 * (NUM_BYTES - 1);
    localparam logic [7:0]       LAST_MASK = 8'((1 << LAST_BITS) - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(3);

    localparam logic [1:0] CODE_MAGIC  = 2'd1;
    localparam logic [1:0] CODE_DEVICE = 2'd2;
    localparam logic [1:0] CODE_SUM    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] byte_cnt;
    logic [15:0]      acc;
    logic [15:0]      exp_sum;
    logic             clear;
    logic             hdr_wr;
    logic             data_wr;
    logic             fail;
    logic [1:0]       fail_code;
    logic             is_last;
    logic [7:0]       masked;

    // Padding bits of the final byte never reach the fuse map or the checksum.
    assign is_last = (byte_cnt == LAST_IDX);
    assign masked  = is_last ? (in_data & LAST_MASK) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        cfg_valid  = 1'b0;
        err        = 1'b0;
        clear      = 1'b0;
        hdr_wr     = 1'b0;
        data_wr    = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'd0;

        case (state)
            IDLE: begin
            end

            HEADER: begin
                busy     = 1'b1;
                in_ready = !start;
                if (!start && in_valid) begin
                    hdr_wr = 1'b1;
                    case (byte_cnt[1:0])
                        2'd0: begin
                            if (in_data != MAGIC) begin
                                fail      = 1'b1;
                                fail_code = CODE_MAGIC;
                            end
                        end
                        2'd1: begin
                            if (in_data != DEVICE_ID) begin
                                fail      = 1'b1;
                                fail_code = CODE_DEVICE;
                            end
                        end
                        default: begin
                        end
                    endcase
                    if (fail) begin
                        state_next = ERROR;
                    end else if (byte_cnt == HDR_LAST) begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                busy     = 1'b1;
                in_ready = !start;
                if (!start && in_valid) begin
                    data_wr = 1'b1;
                    if (is_last) begin
                        state_next = CHECK;
                    end
                end
            end

            CHECK: begin
                busy = 1'b1;
                if (!start) begin
                    if (acc == exp_sum) begin
                        state_next = DONE;
                    end else begin
                        fail       = 1'b1;
                        fail_code  = CODE_SUM;
                        state_next = ERROR;
                    end
                end
            end

            DONE: begin
                cfg_valid = 1'b1;
            end

            ERROR: begin
                err = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A start pulse restarts from any state and wins over the byte on the bus.
        if (start) begin
            clear      = 1'b1;
            state_next = HEADER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            acc      <= '0;
            exp_sum  <= '0;
            err_code <= 2'd0;
        end else if (clear) begin
            byte_cnt <= '0;
            acc      <= '0;
            exp_sum  <= '0;
            err_code <= 2'd0;
        end else begin
            if (hdr_wr) begin
                byte_cnt <= (byte_cnt == HDR_LAST) ? '0 : byte_cnt + 1'b1;
                if (byte_cnt == CNT_W'(2)) begin
                    exp_sum[7:0] <= in_data;
                end
                if (byte_cnt == HDR_LAST) begin
                    exp_sum[15:8] <= in_data;
                end
            end
            if (data_wr) begin
                byte_cnt <= byte_cnt + 1'b1;
                acc      <= acc + {8'h00, masked};
            end
            if (fail) begin
                err_code <= fail_code;
            end
        end
    end

    // Fuse i comes from data byte i/8, bit i%8; bits past NUM_FUSES are never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fuses <= '0;
        end else if (clear) begin
            fuses <= '0;
        end else if (data_wr) begin
            for (int i = 0; i < NUM_FUSES; i++) begin
                if (byte_cnt == CNT_W'(i / 8)) begin
                    fuses[FI_W'(i)] <= in_data[3'(i % 8)];
                end
            end
        end
    end

endmodule

// File: tb/tb_gal_fuse_loader.sv
// Scoreboard bench for gal_fuse_loader: directed images in, a monitor checks
// each completion (cfg_valid or err rising) against the queued expectation.
module tb_gal_fuse_loader;

    localparam int NF   = 2194;
    localparam int NB   = 275;
    localparam int NIMG = 279;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NF-1:0] fuses;
    logic          cfg_valid;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    gal_fuse_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fuses     (fuses),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cfg;
        logic          er;
        logic [1:0]    code;
        logic [NF-1:0] fz;
    } exp_t;

    exp_t       sbq[$];
    int         passCount = 0;
    int         checkCount = 0;
    int         hsCount = 0;
    logic [7:0] img [NIMG];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Data byte k = k[7:0] ^ xorv, last byte 8'hFF (only its low two bits are fuses).
    task automatic buildImage(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [15:0] sum, input logic [7:0] xorv);
        img[0] = b0;
        img[1] = b1;
        img[2] = sum[7:0];
        img[3] = sum[15:8];
        for (int k = 0; k < NB; k++) begin
            img[4 + k] = (k == NB - 1) ? 8'hFF : (8'(k) ^ xorv);
        end
    endtask

    function automatic logic [NF-1:0] modelFuses(input int nData);
        logic [NF-1:0] f;
        f = '0;
        for (int k = 0; k < nData; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (8 * k + b < NF) begin
                    f[8 * k + b] = img[4 + k][b];
                end
            end
        end
        return f;
    endfunction

    task automatic expectResult(input logic cfg, input logic er, input logic [1:0] code, input int nData);
        exp_t e;
        e.cfg  = cfg;
        e.er   = er;
        e.code = code;
        e.fz   = modelFuses(nData);
        sbq.push_back(e);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers img[0..maxBytes-1]; returns just after the last handshake edge or once err is up.
    task automatic applyStimulus(input int maxBytes, input bit gaps);
        int idx;
        int cycles;
        bit hs;
        idx = 0;
        cycles = 0;
        while (idx < maxBytes && !err && cycles < 5000) begin
            in_data  = img[idx];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) idx++;
            cycles++;
        end
        in_valid = 1'b0;
        hsCount = idx;
        if (cycles >= 5000) begin
            checkCount++;
            $display("[TB] FAIL send_budget: sent %0d bytes, expected %0d", idx, maxBytes);
        end
    endtask

    task automatic waitResults();
        int c;
        c = 0;
        while (sbq.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (sbq.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL result_timeout: %0d results pending, expected 0", sbq.size());
            sbq.delete();
        end
        #1;
    endtask

    initial begin : monitor
        bit   prevDone;
        exp_t e;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if ((cfg_valid || err) && !prevDone) begin
                if (sbq.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected_result: cfg_valid=%0b err=%0b, expected no completion",
                             cfg_valid, err);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_cfg_valid", 32'(cfg_valid), 32'(e.cfg));
                    checkOutput("sb_err", 32'(err), 32'(e.er));
                    checkOutput("sb_err_code", 32'(err_code), 32'(e.code));
                    checkOutput("sb_fuses_match", 32'(fuses == e.fz), 32'd1);
                    checkOutput("sb_busy", 32'(busy), 32'd0);
                end
            end
            prevDone = cfg_valid || err;
        end
    end

    initial begin
        #12;
        checkOutput("reset_cfg_valid", 32'(cfg_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_err_code", 32'(err_code), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_fuses_zero", 32'(fuses == '0), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good image: checksum of 0..255, 0..17 and masked 0xFF is 0x801C.
        buildImage(8'h6A, 8'h16, 16'h801C, 8'h00);
        pulseStart();
        checkOutput("good_busy_after_start", 32'(busy), 1);
        expectResult(1'b1, 1'b0, 2'd0, NB);
        applyStimulus(NIMG, 1'b0);
        checkOutput("good_handshakes", hsCount, NIMG);
        checkOutput("good_check_cycle_cfg", 32'(cfg_valid), 0);
        checkOutput("good_check_cycle_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        checkOutput("good_latency_cfg", 32'(cfg_valid), 1);
        checkOutput("good_fuses_2193_2192", 32'(fuses[2193:2192]), 32'h3);
        checkOutput("good_fuses_15_8", 32'(fuses[15:8]), 32'h01);
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("done_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;
        waitResults();

        // Bad magic.
        buildImage(8'h00, 8'h16, 16'h801C, 8'h00);
        pulseStart();
        expectResult(1'b0, 1'b1, 2'd1, 0);
        applyStimulus(NIMG, 1'b0);
        checkOutput("magic_consumed", hsCount, 1);
        checkOutput("magic_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("magic_code_held", 32'(err_code), 1);
        checkOutput("magic_cfg_low", 32'(cfg_valid), 0);
        in_valid = 1'b0;
        waitResults();

        // Bad device id.
        buildImage(8'h6A, 8'h20, 16'h801C, 8'h00);
        pulseStart();
        checkOutput("restart_err_cleared", 32'(err), 0);
        expectResult(1'b0, 1'b1, 2'd2, 0);
        applyStimulus(NIMG, 1'b0);
        checkOutput("device_consumed", hsCount, 2);
        waitResults();

        // Checksum field off by one.
        buildImage(8'h6A, 8'h16, 16'h801D, 8'h00);
        pulseStart();
        expectResult(1'b0, 1'b1, 2'd3, NB);
        applyStimulus(NIMG, 1'b0);
        checkOutput("sum_handshakes", hsCount, NIMG);
        @(posedge clk);
        #1;
        checkOutput("sum_err", 32'(err), 1);
        checkOutput("sum_cfg_low", 32'(cfg_valid), 0);
        waitResults();

        // Good image with random in_valid gaps.
        buildImage(8'h6A, 8'h16, 16'h801C, 8'h00);
        pulseStart();
        expectResult(1'b1, 1'b0, 2'd0, NB);
        applyStimulus(NIMG, 1'b1);
        checkOutput("gaps_handshakes", hsCount, NIMG);
        waitResults();

        // Abort after 100 data bytes of a different image, then reload.
        buildImage(8'h6A, 8'h16, 16'h801C, 8'h5A);
        pulseStart();
        applyStimulus(104, 1'b0);
        checkOutput("abort_busy", 32'(busy), 1);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_fuses_cleared", 32'(fuses == '0), 1);
        buildImage(8'h6A, 8'h16, 16'h801C, 8'h00);
        expectResult(1'b1, 1'b0, 2'd0, NB);
        applyStimulus(NIMG, 1'b0);
        waitResults();

        // Asynchronous reset in the middle of DATA.
        pulseStart();
        applyStimulus(54, 1'b0);
        checkOutput("midreset_busy_before", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_in_ready", 32'(in_ready), 0);
        checkOutput("midreset_fuses_zero", 32'(fuses == '0), 1);
        checkOutput("midreset_err", 32'(err), 0);
        checkOutput("midreset_cfg_valid", 32'(cfg_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midreset_idle_busy", 32'(busy), 0);
        waitResults();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
